// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared constants and types for the APF bridge target-command mailbox
//
// Contents:
//   TARGET_CMD_MAGIC / TARGET_RESULT_MAGIC  upper-half tags of the CMD and RESULT words
//   CMD_OFS, RESULT_OFS, PARAM_OFS, RESP_OFS byte offsets inside the 256-byte window
//   STATUS_TIMEOUT                          status returned when the host never answers
//   target_cmd_id_t                         known core-to-host command IDs
//   tc_state_t                              initiator FSM states
//   word_index()                            byte offset -> 32-bit word index

package bridge_pkg;

   localparam logic [15:0] TARGET_CMD_MAGIC    = 16'h636D;
   localparam logic [15:0] TARGET_RESULT_MAGIC = 16'h7270;

   localparam logic [7:0] CMD_OFS    = 8'h00;
   localparam logic [7:0] RESULT_OFS = 8'h04;
   localparam logic [7:0] PARAM_OFS  = 8'h20;
   localparam logic [7:0] RESP_OFS   = 8'h80;

   localparam logic [15:0] STATUS_TIMEOUT = 16'hFFFF;

   typedef enum logic [15:0] {
      CMD_DATASLOT_READ  = 16'h0180,
      CMD_DATASLOT_WRITE = 16'h0184,
      CMD_DATASLOT_FLUSH = 16'h018A,
      CMD_GET_FILENAME   = 16'h0190,
      CMD_OPEN_FILE      = 16'h0192,
      CMD_DEBUG_LOG      = 16'h01A0
   } target_cmd_id_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } tc_state_t;

   function automatic logic [5:0] word_index(input logic [7:0] ofs);
      return ofs[7:2];
   endfunction

endpackage

// File: rtl/target_cmd_regfile.sv
// rtl/target_cmd_regfile.sv - PARAM/RESP word storage and registered bridge read mux
//
// Ports:
//   clk, reset_n     bridge clock, asynchronous active-low reset
//   load             request accepted: capture load_param, clear all RESP words
//   load_param       NUM_PARAMS*32 parameter words, word 0 in [31:0]
//   resp_wr_en       host RESP writes are currently allowed (FSM in WAIT)
//   addr             window byte offset (addr[7:0] of the bridge address)
//   wr, wr_data      bridge write strobe and data
//   rd               bridge read strobe
//   cmd_word         current CMD word as seen by the host
//   rd_data          read data, registered, updated only on rd
//   resp_data        RESP words, word 0 in [31:0]

module target_cmd_regfile
   import bridge_pkg::*;
#(
   parameter int NUM_PARAMS = 8,
   parameter int NUM_RESP   = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [NUM_PARAMS*32-1:0] load_param,
   input  logic                    resp_wr_en,
   input  logic [7:0]              addr,
   input  logic                    wr,
   input  logic [31:0]             wr_data,
   input  logic                    rd,
   input  logic [31:0]             cmd_word,
   output logic [31:0]             rd_data,
   output logic [NUM_RESP*32-1:0]  resp_data
);

   localparam logic [5:0] CMD_WORD   = word_index(CMD_OFS);
   localparam logic [5:0] PARAM_WORD = word_index(PARAM_OFS);
   localparam logic [5:0] RESP_WORD  = word_index(RESP_OFS);

   logic [31:0] param_q [NUM_PARAMS];
   logic [31:0] resp_q  [NUM_RESP];
   logic [31:0] rd_next;
   logic [5:0]  word;
   logic        aligned;

   // Only word-aligned offsets are decoded; anything else is unmapped.
   assign word    = word_index(addr);
   assign aligned = (addr[1:0] == 2'b00);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PARAMS; i++) param_q[i] <= '0;
         for (int j = 0; j < NUM_RESP; j++)   resp_q[j]  <= '0;
      end else if (load) begin
         for (int i = 0; i < NUM_PARAMS; i++) param_q[i] <= load_param[i*32 +: 32];
         for (int j = 0; j < NUM_RESP; j++)   resp_q[j]  <= '0;
      end else if (wr && resp_wr_en && aligned) begin
         for (int j = 0; j < NUM_RESP; j++) begin
            if (word == 6'(RESP_WORD + j)) resp_q[j] <= wr_data;
         end
      end
   end

   always_comb begin
      rd_next = '0;
      if (aligned) begin
         if (word == CMD_WORD) rd_next = cmd_word;
         for (int i = 0; i < NUM_PARAMS; i++) begin
            if (word == 6'(PARAM_WORD + i)) rd_next = param_q[i];
         end
         for (int j = 0; j < NUM_RESP; j++) begin
            if (word == 6'(RESP_WORD + j)) rd_next = resp_q[j];
         end
      end
   end

   // Read data samples pre-edge state, so a read coinciding with a state
   // change returns the old value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd) begin
         rd_data <= rd_next;
      end
   end

   for (genvar g = 0; g < NUM_RESP; g++) begin : g_resp_out
      assign resp_data[g*32 +: 32] = resp_q[g];
   end

endmodule

// File: rtl/bridge_target_cmd.sv
// rtl/bridge_target_cmd.sv - core-to-host command initiator behind the APF bridge mailbox
//
// Ports:
//   clk, reset_n                         bridge clock, asynchronous active-low reset
//   bridge_addr/wr/wr_data/rd/rd_data    bridge leaf slave; only addr[7:0] decoded,
//                                        read data valid the cycle after bridge_rd
//   req_valid, req_ready, req_cmd,       client request: command ID plus
//   req_param                            NUM_PARAMS parameter words
//   resp_valid, resp_status, resp_data   one-cycle completion pulse, host status
//                                        (STATUS_TIMEOUT on timeout), RESP payload
//   busy                                 command outstanding at the host

module bridge_target_cmd
   import bridge_pkg::*;
#(
   parameter int          NUM_PARAMS     = 8,
   parameter int          NUM_RESP       = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_000_000,
   parameter logic [31:0] BASE_ADDR      = 32'hF8001000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [31:0]              bridge_addr,
   input  logic                     bridge_wr,
   input  logic [31:0]              bridge_wr_data,
   input  logic                     bridge_rd,
   output logic [31:0]              bridge_rd_data,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [15:0]              req_cmd,
   input  logic [NUM_PARAMS*32-1:0] req_param,
   output logic                     resp_valid,
   output logic [15:0]              resp_status,
   output logic [NUM_RESP*32-1:0]   resp_data,
   output logic                     busy
);

   tc_state_t   state_q, state_d;
   logic [15:0] cmd_q;
   logic        pending_q;
   logic [31:0] cnt_q;
   logic [15:0] status_q;
   logic [31:0] cmd_word;
   logic        accept;
   logic        result_hit;
   logic        timeout_hit;

   // The window is leaf-filtered upstream; the base and upper address bits
   // carry no information here.
   logic unused_bits;
   assign unused_bits = ^{bridge_addr[31:8], BASE_ADDR};

   assign accept = (state_q == ST_IDLE) && req_valid;

   // Only a correctly tagged RESULT write in WAIT completes the command.
   assign result_hit = (state_q == ST_WAIT) && bridge_wr &&
                       (bridge_addr[7:0] == RESULT_OFS) &&
                       (bridge_wr_data[31:16] == TARGET_RESULT_MAGIC);

   assign timeout_hit = (state_q == ST_WAIT) && (TIMEOUT_CYCLES != 32'd0) &&
                        (cnt_q == TIMEOUT_CYCLES - 32'd1);

   assign cmd_word = pending_q ? {TARGET_CMD_MAGIC, cmd_q} : 32'd0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      busy       = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (result_hit || timeout_hit) state_d = ST_DONE;
         end
         ST_DONE: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_q     <= '0;
         pending_q <= 1'b0;
         cnt_q     <= '0;
         status_q  <= '0;
      end else if (accept) begin
         cmd_q     <= req_cmd;
         pending_q <= 1'b1;
         cnt_q     <= '0;
      end else if (state_q == ST_WAIT) begin
         // Saturate so a disabled timeout can wait forever without wrapping.
         if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
         // RESULT takes priority over a timeout landing on the same edge.
         if (result_hit) begin
            status_q  <= bridge_wr_data[15:0];
            pending_q <= 1'b0;
            cmd_q     <= '0;
         end else if (timeout_hit) begin
            status_q  <= STATUS_TIMEOUT;
            pending_q <= 1'b0;
            cmd_q     <= '0;
         end
      end
   end

   assign resp_status = status_q;

   target_cmd_regfile #(
      .NUM_PARAMS (NUM_PARAMS),
      .NUM_RESP   (NUM_RESP)
   ) u_regfile (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (accept),
      .load_param (req_param),
      .resp_wr_en (state_q == ST_WAIT),
      .addr       (bridge_addr[7:0]),
      .wr         (bridge_wr),
      .wr_data    (bridge_wr_data),
      .rd         (bridge_rd),
      .cmd_word   (cmd_word),
      .rd_data    (bridge_rd_data),
      .resp_data  (resp_data)
   );

endmodule

// File: doc/bridge_target_cmd.md
Name: bridge_target_cmd

Overview:
Core-to-host command initiator for the APF bridge: the core side of the target-command mailbox, the reverse direction of the host-command responder. A core client hands it a 16-bit command ID plus parameter words. The block publishes them in a bridge-readable mailbox, waits for the host to write a result word and optional response payload, then returns status and payload to the client. It sits as one leaf behind the bridge address decoder, occupying the 0xF8001000–0xF80010FF window on the bridge clock.

Parameters:
NUM_PARAMS, 8, parameter words exposed to the host (1..16)
NUM_RESP, 4, response payload words captured from the host (1..16)
TIMEOUT_CYCLES, 32'd74_000_000, host response timeout in clk cycles (~1 s); 0 disables
BASE_ADDR, 32'hF8001000, mailbox base; only addr[7:0] is decoded inside the block

Ports:
clk  in  1  bridge clock (74.25 MHz)
reset_n  in  1  asynchronous active-low reset
bridge_addr  in  32  bridge byte address (leaf-filtered upstream)
bridge_wr  in  1  bridge write strobe, single cycle
bridge_wr_data  in  32  bridge write data
bridge_rd  in  1  bridge read strobe, single cycle
bridge_rd_data  out  32  read data, valid the cycle after bridge_rd
req_valid  in  1  client command request
req_ready  out  1  block idle, can accept a request
req_cmd  in  16  command ID
req_param  in  NUM_PARAMS*32  parameter words, word 0 in [31:0]
resp_valid  out  1  one-cycle pulse, result available
resp_status  out  16  host result code, or 16'hFFFF on timeout
resp_data  out  NUM_RESP*32  captured response payload
busy  out  1  high from acceptance until resp_valid

Behaviour:
- Interface: one clock `clk`. Reset `reset_n` is asynchronous, active-low.
- Mailbox map, byte offsets from BASE_ADDR:
  - 0x00 CMD: reads 32'h636D_0000|cmd while pending, else 0.
  - 0x04 RESULT: host writes 32'h7270_0000|status; any other upper half is ignored.
  - 0x20+4i: PARAM[i], read-only.
  - 0x80+4j: RESP[j], host-writable.
  - Unmapped reads return 0. Unmapped writes are dropped.
- Reset values: req_ready=1, resp_valid=0, busy=0, resp_status=0, resp_data=0, bridge_rd_data=0, CMD word=0, all PARAM/RESP words=0, timeout counter=0.
- FSM IDLE→WAIT→DONE→IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, in the same edge: latch cmd and params, clear RESP, zero the counter, go to WAIT.
  - CMD reads nonzero from the next cycle.
- WAIT:
  - req_ready=0, busy=1, counter increments each cycle.
  - Host writes to RESP are accepted only in WAIT.
  - A valid RESULT write goes to DONE and latches status[15:0].
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1, go to DONE with status 16'hFFFF.
  - If a valid RESULT write and the timeout land on the same cycle, the RESULT write wins.
- DONE:
  - On entry, CMD is cleared to 0 so the host stops seeing a pending command.
  - resp_valid pulses for exactly one cycle; resp_data is presented from latched RESP and held until the next acceptance.
  - Next state IDLE.
  - Latency: a RESULT write at cycle t gives resp_valid at t+1 and req_ready at t+2.
- RESULT writes outside WAIT are ignored. A RESP write and a RESULT write are never simultaneous (single bridge bus).
- Reads:
  - Registered, one-cycle latency.
  - A read and a state change in the same cycle return the pre-edge value.
  - Reads never alter state.
- Counter is 32 bits wide and saturates; it never wraps.
- Reset mid-WAIT: everything returns to its reset value and no resp_valid is issued.
- req_valid while busy is ignored; the client must hold the request until req_ready.

Decomposition:
- bridge_pkg:
  - TARGET_CMD_MAGIC (16'h636D), TARGET_RESULT_MAGIC (16'h7270).
  - Offset constants CMD_OFS, RESULT_OFS, PARAM_OFS, RESP_OFS.
  - STATUS_TIMEOUT (16'hFFFF).
  - Command ID enum (dataslot read/write/flush, get filename, open file, debug log).
- One sub-module, target_cmd_regfile: PARAM/RESP storage plus the registered read mux. The FSM and timeout counter stay in bridge_target_cmd.

Test Plan:
1. Reset, then bridge reads 0x00, 0x04, 0x20 → all return 0; req_ready=1, busy=0.
2. Request cmd 16'h0180 with PARAM0=32'h0000_0003, then read 0x00 and 0x20 → 32'h636D_0180 and 32'h0000_0003.
3. Host writes RESP0=32'hDEAD_BEEF, then RESULT=32'h7270_0000 at cycle t → resp_valid only at t+1, resp_status=0, resp_data[31:0]=32'hDEAD_BEEF, and 0x00 reads 0.
4. TIMEOUT_CYCLES=100 with no host write → resp_valid exactly 100 cycles after acceptance, resp_status=16'hFFFF.
5. RESULT=32'h1234_0005 (bad magic) in WAIT → ignored and FSM stays in WAIT; RESULT written in IDLE → no resp_valid.
6. reset_n pulsed low mid-WAIT → CMD reads 0, req_ready=1, no resp_valid pulse. A new request afterwards completes normally.
